// File: rtl/rotary_field_editor.sv
// rotary_field_editor: browse/edit controller for a bank of user-adjustable
// registers driven by a rotary encoder and a push button.
// Optional feature macro: ROTARY_ACCEL_EN (accelerated steps while editing).
//
// Input protocol: rotary_event is a single-cycle step pulse with rotary_left
// qualifying its direction only in that cycle; there is no ready/backpressure,
// so every pulse is consumed in the cycle it arrives. push is a debounced level
// whose rising edge is the only thing acted upon.

module rotary_field_editor #(
    parameter int WIDTH          = 8,
    parameter int SEL_WIDTH      = 2,
    parameter int TIMEOUT_CYCLES = 165_000_000,
    parameter int ACCEL_WINDOW   = 3_300_000,
    parameter int ACCEL_STEP     = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 rotary_event,
    input  logic                                 rotary_left,
    input  logic                                 push,
    output logic [SEL_WIDTH-1:0]                 sel,
    output logic                                 editing,
    output logic [WIDTH*(2**SEL_WIDTH)-1:0]      values,
    output logic [WIDTH-1:0]                     edit_value,
    output logic                                 commit,
    output logic                                 cancel,
    output logic                                 fsm_state
);

    localparam int NUM_FIELDS = 2 ** SEL_WIDTH;
    localparam int BANK_W     = WIDTH * NUM_FIELDS;
    localparam int TW         = $clog2(TIMEOUT_CYCLES);

    typedef enum logic {
        BROWSE = 1'b0,
        EDIT   = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [SEL_WIDTH-1:0] sel_nxt;
    logic [WIDTH-1:0]    working;
    logic [WIDTH-1:0]    working_nxt;
    logic [BANK_W-1:0]   values_nxt;
    logic                commit_nxt;
    logic                cancel_nxt;
    logic [TW-1:0]       tmo_cnt;
    logic [TW-1:0]       tmo_nxt;
    logic                push_q;
    logic                push_edge;
    logic [WIDTH:0]      step;
    logic [WIDTH:0]      up_sum;
    logic [WIDTH:0]      dn_diff;
    logic [WIDTH-1:0]    up_sat;
    logic [WIDTH-1:0]    dn_sat;
    logic [WIDTH-1:0]    cur_field;

    assign push_edge = push & ~push_q;
    assign cur_field = values[int'(sel)*WIDTH +: WIDTH];

    // Saturating adjust computed one bit wider so the carry/borrow flags the clamp.
    assign up_sum  = {1'b0, working} + step;
    assign dn_diff = {1'b0, working} - step;
    assign up_sat  = up_sum[WIDTH]  ? {WIDTH{1'b1}} : up_sum[WIDTH-1:0];
    assign dn_sat  = dn_diff[WIDTH] ? {WIDTH{1'b0}} : dn_diff[WIDTH-1:0];

`ifdef ROTARY_ACCEL_EN
    localparam int GW = $clog2(ACCEL_WINDOW + 1);

    logic [GW-1:0] gap_cnt;
    logic          last_left;
    logic          first_evt;

    // Track spacing and direction of encoder events, and whether the next edit
    // event is the first one since entering EDIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt   <= '0;
            last_left <= 1'b0;
            first_evt <= 1'b0;
        end else begin
            if (rotary_event) begin
                gap_cnt   <= '0;
                last_left <= rotary_left;
            end else if (gap_cnt != GW'(ACCEL_WINDOW)) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
            if (state == BROWSE && push_edge) begin
                first_evt <= 1'b1;
            end else if (state == EDIT && rotary_event && !push_edge) begin
                first_evt <= 1'b0;
            end
        end
    end

    assign step = (!first_evt && (gap_cnt < GW'(ACCEL_WINDOW)) && (rotary_left == last_left))
                  ? (WIDTH+1)'(ACCEL_STEP) : (WIDTH+1)'(1);
`else
    assign step = (WIDTH+1)'(1);
`endif

    // Next-state and datapath decisions; push edge outranks rotation, rotation outranks timeout.
    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel;
        working_nxt = working;
        values_nxt  = values;
        commit_nxt  = 1'b0;
        cancel_nxt  = 1'b0;
        tmo_nxt     = tmo_cnt;
        unique case (state)
            BROWSE: begin
                if (push_edge) begin
                    state_nxt   = EDIT;
                    working_nxt = cur_field;
                    tmo_nxt     = '0;
                end else if (rotary_event) begin
                    sel_nxt = rotary_left ? sel - 1'b1 : sel + 1'b1;
                end
            end
            EDIT: begin
                if (push_edge) begin
                    values_nxt[int'(sel)*WIDTH +: WIDTH] = working;
                    commit_nxt = 1'b1;
                    state_nxt  = BROWSE;
                    tmo_nxt    = '0;
                end else if (rotary_event) begin
                    working_nxt = rotary_left ? dn_sat : up_sat;
                    tmo_nxt     = '0;
                end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 2)) begin
                    cancel_nxt = 1'b1;
                    state_nxt  = BROWSE;
                    tmo_nxt    = '0;
                end else if (tmo_cnt != {TW{1'b1}}) begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
            default: state_nxt = BROWSE;
        endcase
    end

    // State, field bank and output pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BROWSE;
            sel     <= '0;
            working <= '0;
            values  <= '0;
            commit  <= 1'b0;
            cancel  <= 1'b0;
            tmo_cnt <= '0;
            push_q  <= 1'b1;
        end else begin
            state   <= state_nxt;
            sel     <= sel_nxt;
            working <= working_nxt;
            values  <= values_nxt;
            commit  <= commit_nxt;
            cancel  <= cancel_nxt;
            tmo_cnt <= tmo_nxt;
            push_q  <= push;
        end
    end

    assign editing    = state;
    assign fsm_state  = state;
    assign edit_value = editing ? working : cur_field;

endmodule

// File: tb/tb_rotary_field_editor.sv
// Self-checking bench for rotary_field_editor: a table of directed vectors,
// directed multi-cycle sequences and randomized traffic, all compared every
// cycle against a behavioural model of the menu/edit rules.

module tb_rotary_field_editor;

    localparam int W    = 8;
    localparam int SW   = 2;
    localparam int NF   = 4;
    localparam int TMO  = 16;
    localparam int AW   = 8;
    localparam int AS   = 4;
    localparam int MAXV = 255;
`ifdef ROTARY_ACCEL_EN
    localparam int ACC = 1;
`else
    localparam int ACC = 0;
`endif
    localparam int S = (ACC != 0) ? AS : 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rotary_event = 1'b0;
    logic          rotary_left = 1'b0;
    logic          push = 1'b0;
    logic [SW-1:0] sel;
    logic          editing;
    logic [W*NF-1:0] values;
    logic [W-1:0]  edit_value;
    logic          commit;
    logic          cancel;
    logic          fsm_state;

    // clock / reset block
    always #5 clk = ~clk;

    rotary_field_editor #(
        .WIDTH(W), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(TMO),
        .ACCEL_WINDOW(AW), .ACCEL_STEP(AS)
    ) dut (
        .clk(clk), .rst(rst), .rotary_event(rotary_event), .rotary_left(rotary_left),
        .push(push), .sel(sel), .editing(editing), .values(values),
        .edit_value(edit_value), .commit(commit), .cancel(cancel), .fsm_state(fsm_state)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // behavioural model state
    bit m_edit;
    int m_sel;
    int m_vals[NF];
    int m_work;
    bit m_push_prev;
    int m_last_act;
    int m_last_ev;
    bit m_last_left;
    bit m_first;
    bit m_commit;
    bit m_cancel;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic logic [W*NF-1:0] bank();
        logic [W*NF-1:0] b;
        b = '0;
        for (int i = 0; i < NF; i++) b[i*W +: W] = W'(m_vals[i]);
        return b;
    endfunction

    // One clock edge of the menu rules, applied to the inputs sampled at that edge.
    task automatic model_step(input bit r, input bit ev, input bit lf, input bit p);
        bit pe;
        int st;
        m_commit = 1'b0;
        m_cancel = 1'b0;
        if (r) begin
            m_edit = 1'b0; m_sel = 0; m_work = 0; m_push_prev = 1'b1;
            for (int i = 0; i < NF; i++) m_vals[i] = 0;
            m_last_act = cyc; m_last_ev = cyc; m_last_left = 1'b0; m_first = 1'b0;
        end else begin
            pe = p && !m_push_prev;
            m_push_prev = p;
            st = 1;
            if (ACC != 0 && !m_first && (cyc - m_last_ev - 1) < AW && lf == m_last_left) st = AS;
            if (!m_edit) begin
                if (pe) begin
                    m_edit = 1'b1; m_work = m_vals[m_sel]; m_last_act = cyc; m_first = 1'b1;
                end else if (ev) begin
                    m_sel = lf ? (m_sel + NF - 1) % NF : (m_sel + 1) % NF;
                end
            end else begin
                if (pe) begin
                    m_vals[m_sel] = m_work; m_commit = 1'b1; m_edit = 1'b0;
                end else if (ev) begin
                    m_work = lf ? ((m_work - st < 0) ? 0 : m_work - st)
                                : ((m_work + st > MAXV) ? MAXV : m_work + st);
                    m_last_act = cyc; m_first = 1'b0;
                end else if (cyc - m_last_act == TMO - 1) begin
                    m_cancel = 1'b1; m_edit = 1'b0;
                end
            end
            if (ev) begin
                m_last_ev = cyc; m_last_left = lf;
            end
        end
    endtask

    // driver task: apply inputs for one cycle, advance the model, compare everything
    task automatic tick(input logic r, input logic ev, input logic lf, input logic p);
        rst = r; rotary_event = ev; rotary_left = lf; push = p;
        @(posedge clk);
        cyc++;
        model_step(r, ev, lf, p);
        #1;
        check("sel", 64'(sel), 64'(m_sel));
        check("editing", 64'(editing), 64'(m_edit));
        check("values", 64'(values), 64'(bank()));
        check("edit_value", 64'(edit_value), 64'(m_edit ? m_work : m_vals[m_sel]));
        check("commit", 64'(commit), 64'(m_commit));
        check("cancel", 64'(cancel), 64'(m_cancel));
    endtask

    task automatic press();
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // event followed by enough idle cycles to defeat acceleration but not reach timeout
    task automatic spaced(input logic lf);
        tick(1'b0, 1'b1, lf, 1'b0);
        repeat (9) tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic goto_field(input int s);
        for (int k = 0; k < NF; k++)
            if (m_sel != s) tick(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic set_field(input int s, input int target);
        int n;
        goto_field(s);
        press();
        n = target - m_vals[s];
        for (int k = 0; k < (n < 0 ? -n : n); k++) spaced(n < 0);
        press();
    endtask

    typedef struct {
        logic r; logic ev; logic lf; logic p;
        int   e_sel; logic e_ed; logic e_cm; logic e_cn; int e_val;
    } vec_t;

    vec_t tv[15];

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : main
        int k;
        int ev_pct;
        logic pl;

        // browse wrap, then edit field 3 with 5 right steps and commit
        tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0};
        tv[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 0};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 0};
        tv[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 0};
        tv[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0};
        tv[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 0};
        tv[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0, 0};
        tv[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1};
        tv[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1 + S};
        tv[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1 + 2*S};
        tv[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1 + 3*S};
        tv[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1 + 4*S};
        tv[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b1, 1'b0, 1 + 4*S};
        tv[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1 + 4*S};
        tv[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1 + 4*S};

        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            tick(tv[i].r, tv[i].ev, tv[i].lf, tv[i].p);
            check("tv_sel", 64'(sel), 64'(tv[i].e_sel));
            check("tv_editing", 64'(editing), 64'(tv[i].e_ed));
            check("tv_commit", 64'(commit), 64'(tv[i].e_cm));
            check("tv_cancel", 64'(cancel), 64'(tv[i].e_cn));
            check("tv_edit_value", 64'(edit_value), 64'(tv[i].e_val));
        end
        check("tv_bank", 64'(values), 64'((1 + 4*S) << 24));

        // saturation high: 253 + 5 right -> 255
        set_field(0, 253);
        check("sat_hi_setup", 64'(values[0 +: W]), 64'd253);
        press();
        for (int i = 0; i < 5; i++) spaced(1'b0);
        check("sat_hi_work", 64'(edit_value), 64'd255);
        press();
        check("sat_hi_commit", 64'(values[0 +: W]), 64'd255);

        // saturation low: 3 + 10 left -> 0
        set_field(1, 3);
        press();
        for (int i = 0; i < 10; i++) spaced(1'b1);
        check("sat_lo_work", 64'(edit_value), 64'd0);
        press();
        check("sat_lo_commit", 64'(values[W +: W]), 64'd0);

        // timeout: enter field 2, two steps, then idle until cancel
        goto_field(2);
        press();
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        k = -1;
        for (int i = 1; i <= 40 && k < 0; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            if (cancel) k = i;
        end
        check("timeout_idle_cycles", 64'(k), 64'(TMO - 1));
        check("timeout_field", 64'(values[2*W +: W]), 64'd0);
        check("timeout_editing", 64'(editing), 64'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("cancel_single", 64'(cancel), 64'd0);

        // push edge and right event together: event dropped, 7 committed
        press();
        for (int i = 0; i < 7; i++) spaced(1'b0);
        check("collide_work", 64'(edit_value), 64'd7);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        check("collide_commit", 64'(commit), 64'd1);
        check("collide_value", 64'(values[2*W +: W]), 64'd7);
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // reset mid-edit
        press();
        spaced(1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_sel", 64'(sel), 64'd0);
        check("rst_editing", 64'(editing), 64'd0);
        check("rst_values", 64'(values), 64'd0);
        check("rst_edit_value", 64'(edit_value), 64'd0);
        check("rst_pulses", 64'({commit, cancel}), 64'd0);

        // push held through reset release: no edit entry
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            check("held_push_no_edit", 64'(editing), 64'd0);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // acceleration: +1, +S, +S, long gap +1, reversal -1
        press();
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("accel_1", 64'(edit_value), 64'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("accel_2", 64'(edit_value), 64'(1 + S));
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("accel_3", 64'(edit_value), 64'(1 + 2*S));
        repeat (12) tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("accel_gap", 64'(edit_value), 64'(2 + 2*S));
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        check("accel_reverse", 64'(edit_value), 64'(1 + 2*S));
        press();
        check("accel_commit", 64'(values[0 +: W]), 64'(1 + 2*S));

        // randomized traffic against the model
        pl = 1'b0;
        ev_pct = 50;
        for (int i = 0; i < 2000; i++) begin
            if (i % 100 == 0) ev_pct = ($urandom_range(0, 1) == 1) ? 50 : 4;
            if ($urandom_range(0, 5) == 0) pl = ~pl;
            tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < ev_pct),
                 1'($urandom_range(0, 1)), pl);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
